com8_tx_sched: RTL and testbench
================================

Name: com8_tx_sched

Overview:
- Transmit-side scheduler for the com8 UART register bridge. Runs on the 12 MHz clock at 115200 baud.
- Watches the eight 8-bit output channels and tracks a pending flag per channel. A flag is set when a channel changes value or when the host explicitly reads that channel.
- Shares the single UART byte transmitter between the eight channels using round-robin arbitration.
- Each granted channel is serialised as a 5-byte ASCII frame: TAG, address digit, hex high nibble, hex low nibble, TERM. It sits between the com8 register file/command decoder and the UART TX byte engine.

Parameters:
- TAG, 8'h44, first byte of every frame ('D').
- TERM, 8'h0A, last byte of every frame ('\n').
- CHANGE_EN, 8'hFF, per-channel enable for change-triggered reports. Host read requests are honoured regardless of this mask.

Ports:
- CLK  in  1  system clock, 12 MHz.
- RST_N  in  1  reset, asynchronous, active-low.
- CH_DATA  in  64  channel n value occupies bits [8n+7:8n], n = 0..7.
- RD_STB  in  1  one-cycle host read request, decoded from an incoming read command.
- RD_ADDR  in  3  channel selected by RD_STB.
- TX_DATA  out  8  byte presented to the UART TX engine.
- TX_VALID  out  1  TX_DATA is valid.
- TX_READY  in  1  UART TX engine can accept a byte.
- BUSY  out  1  a frame is in progress.

Behaviour:
- Reset (RST_N low, asynchronous):
  - TX_VALID=0, TX_DATA=8'h00, BUSY=0.
  - shadow[0..7]=0, pending=0, last-served pointer=7 (so channel 0 has priority first).
  - State = IDLE. Asserting reset mid-frame aborts the frame immediately; no partial frame is resumed.
- Change detect, per channel n, registered:
  - If CHANGE_EN[n] and CH_DATA[n] != shadow[n], pending[n] is set at the next edge.
- Read request:
  - RD_STB sets pending[RD_ADDR] at the next edge.
  - A duplicate request for an already-pending channel merges into that flag; it does not produce a second frame.
- Arbitration:
  - Round-robin. Search starts at last+1 and wraps 7→0; the first pending channel wins.
  - Arbiter output is combinational from pending and last.
- FSM states: IDLE, TAG, ADDR, HI, LO, TRM.
- IDLE:
  - If any pending bit is set, on the next edge: latch the channel index and CH_DATA[ch] into the frame register.
  - On that same edge: shadow[ch] ← latched value, pending[ch] cleared, last ← ch, BUSY=1, TX_VALID=1, TX_DATA=TAG, state → TAG.
  - A set and a clear of the same pending bit in the same cycle resolve as set. A concurrent change or RD_STB is therefore never lost.
- Byte states:
  - The byte advances only on a cycle with TX_VALID && TX_READY.
  - While TX_READY=0, TX_DATA and TX_VALID hold stable.
  - Byte sequence:
    - TAG.
    - ADDR = 8'h30 + ch.
    - HI = hex(value[7:4]).
    - LO = hex(value[3:0]).
    - TRM = TERM.
  - hex(): 0-9 → 8'h30-8'h39; A-F → 8'h41-8'h46 (uppercase).
- Frame completion:
  - Acceptance in TRM → IDLE, TX_VALID=0, BUSY=0 for exactly one cycle, even if more channels are pending.
- Timing:
  - TX_VALID rises ≤2 cycles after a change or RD_STB when idle.
  - Back-to-back frames with TX_READY tied high are 6 cycles apart.
- In-flight data:
  - CH_DATA changes during a frame do not alter bytes already in flight. They raise pending for a later frame.

Decomposition:
- com8_pkg:
  - state enum.
  - ASCII constants TAG_D, TERM_LF, ASCII_0, ASCII_A.
  - function hex_nibble(4b) → 8b.
  - channel count constant NCH=8.
- Sub-module com8_rr_arb:
  - 8-way combinational round-robin arbiter.
  - Inputs: req[7:0], last[2:0].
  - Outputs: gnt_valid, gnt_idx[2:0].

Test Plan:
- Reset, CH_DATA=0, TX_READY=1, 1000 cycles → TX_VALID never asserts, BUSY=0.
- CH_DATA ch0 ← 8'd155 (0x9B) → accepted bytes 44 30 39 42 0A on 5 consecutive cycles, then BUSY=0.
- ch5 ← 8'hAA during the ch0 frame → ch0 frame completes intact, then frame 44 35 41 41 0A.
- ch2 and ch6 change in the same cycle, last=5 → ch6 frame first, then ch2. Second case: same-cycle change on ch7 and ch0 with last=7 → ch0 first.
- TX_READY held low 20 cycles during HI byte → TX_DATA stays 8'h39, no byte dropped or duplicated. A CH_DATA change on the active channel mid-frame leaves the frame unchanged and triggers one follow-up frame with the new value.
- Read request cases:
  - RD_STB with RD_ADDR=3, ch3=0x00 unchanged → 44 33 30 30 0A.
  - RD_STB twice while ch3 is pending → only one frame.
  - RST_N low during ADDR byte → TX_VALID=0 asynchronously, no further bytes after release until a new change occurs.

Source files
------------

// File: rtl/com8_pkg.sv
// Shared types, ASCII constants and helpers for the com8 transmit scheduler.
package com8_pkg;

  localparam int unsigned NCH    = 8;
  localparam int unsigned CH_W   = 3;
  localparam int unsigned BYTE_W = 8;

  localparam logic [BYTE_W-1:0] TAG_D   = 8'h44;
  localparam logic [BYTE_W-1:0] TERM_LF = 8'h0A;
  localparam logic [BYTE_W-1:0] ASCII_0 = 8'h30;
  localparam logic [BYTE_W-1:0] ASCII_A = 8'h41;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TAG,
    ST_ADDR,
    ST_HI,
    ST_LO,
    ST_TRM
  } state_t;

  // Uppercase ASCII hex digit for one nibble.
  function automatic logic [BYTE_W-1:0] hex_nibble(input logic [3:0] nib);
    logic [BYTE_W-1:0] r;
    if (nib < 4'd10) r = ASCII_0 + BYTE_W'(nib);
    else             r = ASCII_A + BYTE_W'(nib - 4'd10);
    return r;
  endfunction

endpackage

// File: rtl/com8_tx_sched_if.sv
// Byte handshake between the scheduler and the UART TX byte engine.
interface com8_tx_sched_if;
  import com8_pkg::*;

  logic [BYTE_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/com8_rr_arb.sv
// Combinational 8-way round-robin arbiter; search starts just after the last winner.
module com8_rr_arb
  import com8_pkg::*;
(
  input  logic [NCH-1:0]  req,
  input  logic [CH_W-1:0] last,
  output logic            gnt_valid,
  output logic [CH_W-1:0] gnt_idx
);

  logic [CH_W-1:0] idx;

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = last;
    idx       = last;
    for (int i = 1; i <= NCH; i++) begin
      idx = last + CH_W'(i);
      if (!gnt_valid && req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/com8_tx_sched.sv
// Change/read-triggered channel reporter: arbitrates pending channels and
// serialises each as a 5-byte ASCII frame onto the UART TX byte handshake.
module com8_tx_sched
  import com8_pkg::*;
#(
  parameter logic [BYTE_W-1:0] TAG       = TAG_D,
  parameter logic [BYTE_W-1:0] TERM      = TERM_LF,
  parameter logic [NCH-1:0]    CHANGE_EN = 8'hFF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NCH*BYTE_W-1:0]   ch_data,
  input  logic                    rd_stb,
  input  logic [CH_W-1:0]         rd_addr,
  com8_tx_sched_if.master         tx,
  output logic                    busy
);

  state_t            state, state_nxt;
  logic [CH_W-1:0]   ch_q, ch_nxt;
  logic [BYTE_W-1:0] val_q, val_nxt;
  logic [CH_W-1:0]   last, last_nxt;
  logic [NCH-1:0]    pending, pend_nxt, pend_set, pend_clr;
  logic [BYTE_W-1:0] shadow     [NCH];
  logic [BYTE_W-1:0] shadow_nxt [NCH];
  logic [BYTE_W-1:0] ch_byte    [NCH];
  logic [BYTE_W-1:0] data_nxt;
  logic              valid_nxt, busy_nxt;
  logic              accept;
  logic              gnt_valid;
  logic [CH_W-1:0]   gnt_idx;

  assign accept = tx.tx_valid && tx.tx_ready;

  com8_rr_arb u_arb (
    .req       (pending),
    .last      (last),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      ch_q        <= '0;
      val_q       <= '0;
      last        <= CH_W'(NCH - 1);
      pending     <= '0;
      shadow      <= '{default: '0};
      tx.tx_data  <= '0;
      tx.tx_valid <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      ch_q        <= ch_nxt;
      val_q       <= val_nxt;
      last        <= last_nxt;
      pending     <= pend_nxt;
      shadow      <= shadow_nxt;
      tx.tx_data  <= data_nxt;
      tx.tx_valid <= valid_nxt;
      busy        <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    ch_nxt     = ch_q;
    val_nxt    = val_q;
    last_nxt   = last;
    shadow_nxt = shadow;
    data_nxt   = tx.tx_data;
    valid_nxt  = tx.tx_valid;
    busy_nxt   = busy;
    pend_clr   = '0;
    pend_set   = '0;
    for (int n = 0; n < NCH; n++) ch_byte[n] = ch_data[n*BYTE_W +: BYTE_W];

    unique case (state)
      ST_IDLE: if (gnt_valid) begin
        ch_nxt              = gnt_idx;
        val_nxt             = ch_byte[gnt_idx];
        shadow_nxt[gnt_idx] = ch_byte[gnt_idx];
        pend_clr[gnt_idx]   = 1'b1;
        last_nxt            = gnt_idx;
        busy_nxt            = 1'b1;
        valid_nxt           = 1'b1;
        data_nxt            = TAG;
        state_nxt           = ST_TAG;
      end
      ST_TAG: if (accept) begin
        data_nxt  = ASCII_0 + BYTE_W'(ch_q);
        state_nxt = ST_ADDR;
      end
      ST_ADDR: if (accept) begin
        data_nxt  = hex_nibble(val_q[7:4]);
        state_nxt = ST_HI;
      end
      ST_HI: if (accept) begin
        data_nxt  = hex_nibble(val_q[3:0]);
        state_nxt = ST_LO;
      end
      ST_LO: if (accept) begin
        data_nxt  = TERM;
        state_nxt = ST_TRM;
      end
      ST_TRM: if (accept) begin
        data_nxt  = '0;
        valid_nxt = 1'b0;
        busy_nxt  = 1'b0;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase

    // Compare against the post-latch shadow so the value being framed is not re-flagged.
    for (int n = 0; n < NCH; n++) begin
      pend_set[n] = (CHANGE_EN[n] && (ch_byte[n] != shadow_nxt[n])) ||
                    (rd_stb && (rd_addr == CH_W'(n)));
    end
    pend_nxt = (pending & ~pend_clr) | pend_set;
  end

endmodule

// File: tb/tb_com8_tx_sched.sv
// Directed bench for com8_tx_sched: single-frame vector table plus multi-frame sequences.
module tb_com8_tx_sched;
  import com8_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] ch_data = '0;
  logic        rd_stb = 1'b0;
  logic [2:0]  rd_addr = '0;
  logic        busy;

  com8_tx_sched_if tx_if ();

  com8_tx_sched dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ch_data (ch_data),
    .rd_stb  (rd_stb),
    .rd_addr (rd_addr),
    .tx      (tx_if),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;
  logic [7:0] capq[$];
  int         capcyc[$];
  bit         seen_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Bytes are recorded mid-cycle: valid && ready here means the next edge accepts.
  always @(negedge clk) begin
    if (tx_if.tx_valid) seen_valid = 1'b1;
    if (tx_if.tx_valid && tx_if.tx_ready) begin
      capq.push_back(tx_if.tx_data);
      capcyc.push_back(cyc);
    end
  end

  typedef struct packed {
    logic [2:0]  ch;
    logic [7:0]  val;
    logic        rd;
    logic [39:0] exp;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clear_cap();
    capq.delete();
    capcyc.delete();
  endtask

  task automatic wait_bytes(input string nm, input int n);
    int b = 0;
    while (capq.size() < n && b < 200) begin
      @(negedge clk); #1;
      b++;
    end
    if (capq.size() < n) check({nm, "_timeout"}, 32'(capq.size()), 32'(n));
  endtask

  task automatic settle(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic check_seq(input string nm, input logic [79:0] exp, input int n);
    logic [7:0] act;
    check({nm, "_count"}, 32'(capq.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      act = (i < capq.size()) ? capq[i] : 8'hxx;
      check($sformatf("%s_byte%0d", nm, i), {24'h0, act}, {24'h0, exp[8*(n-1-i) +: 8]});
    end
  endtask

  task automatic drive_ch(input int ch, input logic [7:0] v);
    ch_data[8*ch +: 8] = v;
  endtask

  initial begin
    int t0;
    int lat;
    int stall_bad;

    vecs[0] = '{ch: 3'd0, val: 8'h9B, rd: 1'b0, exp: 40'h44_30_39_42_0A};
    vecs[1] = '{ch: 3'd3, val: 8'h00, rd: 1'b1, exp: 40'h44_33_30_30_0A};
    vecs[2] = '{ch: 3'd7, val: 8'hF0, rd: 1'b0, exp: 40'h44_37_46_30_0A};
    vecs[3] = '{ch: 3'd4, val: 8'h0A, rd: 1'b0, exp: 40'h44_34_30_41_0A};
    vecs[4] = '{ch: 3'd1, val: 8'h5E, rd: 1'b0, exp: 40'h44_31_35_45_0A};

    tx_if.tx_ready = 1'b1;
    #1;
    check("rst_valid", {31'h0, tx_if.tx_valid}, 32'h0);
    check("rst_data", {24'h0, tx_if.tx_data}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    settle(3);
    rst_n = 1'b1;

    // Quiet inputs must never start a frame.
    seen_valid = 1'b0;
    settle(1000);
    check("idle_no_valid", {31'h0, seen_valid}, 32'h0);
    check("idle_busy", {31'h0, busy}, 32'h0);

    for (int v = 0; v < 5; v++) begin
      clear_cap();
      @(posedge clk); #1;
      t0 = cyc;
      if (vecs[v].rd) begin
        rd_addr = vecs[v].ch;
        rd_stb  = 1'b1;
        @(posedge clk); #1;
        rd_stb  = 1'b0;
      end else begin
        drive_ch(int'(vecs[v].ch), vecs[v].val);
      end
      wait_bytes($sformatf("vec%0d", v), 5);
      settle(10);
      check_seq($sformatf("vec%0d", v), {40'h0, vecs[v].exp}, 5);
      lat = (capcyc.size() > 0) ? capcyc[0] - t0 : -1;
      check($sformatf("vec%0d_latency_le2", v), {31'h0, (lat >= 1 && lat <= 2)}, 32'h1);
      check($sformatf("vec%0d_span", v), (capcyc.size() >= 5) ? 32'(capcyc[4] - capcyc[0]) : 32'hFFFF, 32'd4);
      check($sformatf("vec%0d_busy_after", v), {31'h0, busy}, 32'h0);
    end

    // Change on another channel during a frame queues a second frame 6 cycles later.
    clear_cap();
    @(posedge clk); #1;
    drive_ch(0, 8'h12);
    wait_bytes("inflight", 2);
    @(posedge clk); #1;
    drive_ch(5, 8'hAA);
    wait_bytes("inflight", 10);
    settle(15);
    check_seq("inflight", 80'h44_30_31_32_0A_44_35_41_41_0A, 10);
    check("b2b_spacing", (capcyc.size() >= 6) ? 32'(capcyc[5] - capcyc[0]) : 32'hFFFF, 32'd6);

    // last=5: simultaneous ch2/ch6 serves ch6 first.
    clear_cap();
    @(posedge clk); #1;
    drive_ch(2, 8'h21);
    drive_ch(6, 8'h63);
    wait_bytes("rr_6_2", 10);
    settle(15);
    check_seq("rr_6_2", 80'h44_36_36_33_0A_44_32_32_31_0A, 10);

    clear_cap();
    @(posedge clk); #1;
    drive_ch(7, 8'h77);
    wait_bytes("rr_pre7", 5);
    settle(10);
    check_seq("rr_pre7", {40'h0, 40'h44_37_37_37_0A}, 5);

    // last=7: simultaneous ch7/ch0 wraps to ch0 first.
    clear_cap();
    @(posedge clk); #1;
    drive_ch(7, 8'h01);
    drive_ch(0, 8'hC4);
    wait_bytes("rr_wrap", 10);
    settle(15);
    check_seq("rr_wrap", 80'h44_30_43_34_0A_44_37_30_31_0A, 10);

    // Backpressure during HI byte plus an active-channel change mid-frame.
    clear_cap();
    @(posedge clk); #1;
    drive_ch(0, 8'h9B);
    wait_bytes("stall", 2);
    @(posedge clk); #1;
    tx_if.tx_ready = 1'b0;
    stall_bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx_if.tx_data !== 8'h39 || tx_if.tx_valid !== 1'b1) stall_bad++;
      if (i == 10) drive_ch(0, 8'h3C);
    end
    check("stall_hold", 32'(stall_bad), 32'd0);
    check("stall_no_accept", 32'(capq.size()), 32'd2);
    @(posedge clk); #1;
    tx_if.tx_ready = 1'b1;
    wait_bytes("stall", 10);
    settle(20);
    check_seq("stall", 80'h44_30_39_42_0A_44_30_33_43_0A, 10);

    // Two read requests for ch3 while it is still pending yield one frame.
    clear_cap();
    @(posedge clk); #1;
    tx_if.tx_ready = 1'b0;
    drive_ch(1, 8'h00);
    settle(4);
    rd_addr = 3'd3;
    rd_stb  = 1'b1;
    @(posedge clk); #1;
    rd_stb  = 1'b0;
    settle(3);
    rd_stb  = 1'b1;
    @(posedge clk); #1;
    rd_stb  = 1'b0;
    settle(3);
    tx_if.tx_ready = 1'b1;
    wait_bytes("rd_merge", 10);
    settle(20);
    check_seq("rd_merge", 80'h44_31_30_30_0A_44_33_30_30_0A, 10);

    // Reset in the middle of the ADDR byte aborts the frame.
    clear_cap();
    @(posedge clk); #1;
    drive_ch(2, 8'h55);
    wait_bytes("mid_rst", 1);
    @(posedge clk); #1;
    check("mid_rst_addr_byte", {24'h0, tx_if.tx_data}, 32'h32);
    rst_n   = 1'b0;
    ch_data = '0;
    #1;
    check("mid_rst_valid", {31'h0, tx_if.tx_valid}, 32'h0);
    check("mid_rst_busy", {31'h0, busy}, 32'h0);
    check("mid_rst_data", {24'h0, tx_if.tx_data}, 32'h0);
    settle(3);
    rst_n = 1'b1;
    clear_cap();
    seen_valid = 1'b0;
    settle(30);
    check("post_rst_quiet", {31'h0, seen_valid}, 32'h0);
    check("post_rst_nobytes", 32'(capq.size()), 32'd0);
    drive_ch(4, 8'h80);
    wait_bytes("post_rst", 5);
    settle(10);
    check_seq("post_rst", {40'h0, 40'h44_34_38_30_0A}, 5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
